pipelined_complementer: RTL



---
 rtl/complementer_pkg.sv | 8 +
 rtl/complement_lane.sv | 26 ++
 rtl/pipelined_complementer.sv | 65 ++++++
 3 files changed

// File: rtl/complementer_pkg.sv
// complementer_pkg: mode encoding shared by the complementer pipeline and its lanes
package complementer_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_PASS = 2'b00;
  localparam mode_t MODE_ONES = 2'b01;
  localparam mode_t MODE_TWOS = 2'b10;
  localparam mode_t MODE_ABS  = 2'b11;
endpackage

// File: rtl/complement_lane.sv
// complement_lane: combinational pass/one's/two's/abs complement of one lane with overflow flag
module complement_lane
  import complementer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  mode_t            mode,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  logic [WIDTH-1:0] neg;
  logic [WIDTH-1:0] res;
  logic             most_neg;
  assign neg      = ~x + WIDTH'(1);
  assign most_neg = x == {1'b1, {(WIDTH-1){1'b0}}};
  // select the operation; negation modes wrap the most negative value onto itself
  always_comb begin
    res = mode == MODE_ONES ? ~x :
          mode == MODE_TWOS ? neg :
          mode == MODE_ABS  ? (x[WIDTH-1] ? neg : x) : x;
    y   = en ? res : x;
    ovf = en && mode[1] && most_neg;
  end
endmodule

// File: rtl/pipelined_complementer.sv
// pipelined_complementer: multi-lane complement unit with a STAGES-deep valid/ready pipeline
module pipelined_complementer
  import complementer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  mode_t                  in_mode,
  input  logic [LANES-1:0]       in_lane_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_ovf,
  output logic [15:0]            txn_count
);
  logic [LANES*WIDTH-1:0] data_d;
  logic [LANES-1:0]       ovf_d;
  logic [LANES*WIDTH-1:0] data_q [STAGES];
  logic [LANES-1:0]       ovf_q  [STAGES];
  logic [STAGES-1:0]      vld_q;
  logic                   stall;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    complement_lane #(.WIDTH(WIDTH)) u_lane (
      .x    (in_data[i*WIDTH +: WIDTH]),
      .mode (in_mode),
      .en   (in_lane_en[i]),
      .y    (data_d[i*WIDTH +: WIDTH]),
      .ovf  (ovf_d[i])
    );
  end
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  // whole pipeline advances together unless the last stage is blocked; bubbles carry zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      txn_count <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        ovf_q[s]  <= '0;
      end
    end else begin
      if (!stall) begin
        vld_q[0]  <= in_valid;
        data_q[0] <= in_valid ? data_d : '0;
        ovf_q[0]  <= in_valid ? ovf_d : '0;
        for (int s = 1; s < STAGES; s++) begin
          vld_q[s]  <= vld_q[s-1];
          data_q[s] <= data_q[s-1];
          ovf_q[s]  <= ovf_q[s-1];
        end
      end
      if (out_valid && out_ready) txn_count <= txn_count + 16'd1;
    end
  end
endmodule
